// File: rtl/arm_control_pkg.sv
// arm_control_pkg
// Shared definitions for the multicycle Armv4 control unit: the controller
// state enum, datapath select encodings, data-processing opcodes, condition
// codes and the condition evaluation helper.
// No ports (package).

package arm_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_LINK     = 4'd10
    } control_state_t;

    // ALU_control encodings
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // ALU_source_b encodings
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;
    localparam logic [1:0] SRCB_ZERO = 2'b11;

    // result_source encodings
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Instruction class (instruction[27:26])
    localparam logic [1:0] OP_DP     = 2'b00;
    localparam logic [1:0] OP_MEM    = 2'b01;
    localparam logic [1:0] OP_BRANCH = 2'b10;

    // Data-processing opcodes (funct[4:1])
    localparam logic [3:0] DP_AND = 4'b0000;
    localparam logic [3:0] DP_SUB = 4'b0010;
    localparam logic [3:0] DP_ADD = 4'b0100;
    localparam logic [3:0] DP_CMP = 4'b1010;
    localparam logic [3:0] DP_ORR = 4'b1100;

    localparam logic [3:0] REG_PC = 4'd15;

    // Condition codes
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Evaluate an Armv4 condition against {N,Z,C,V}. The 1111 space is
    // treated as never-execute.
    function automatic logic cond_holds(input logic [3:0] cond,
                                        input logic [3:0] flags);
        logic n, z, c, v;
        n = flags[3];
        z = flags[2];
        c = flags[1];
        v = flags[0];
        case (cond)
            COND_EQ: cond_holds = z;
            COND_NE: cond_holds = !z;
            COND_CS: cond_holds = c;
            COND_CC: cond_holds = !c;
            COND_MI: cond_holds = n;
            COND_PL: cond_holds = !n;
            COND_VS: cond_holds = v;
            COND_VC: cond_holds = !v;
            COND_HI: cond_holds = c && !z;
            COND_LS: cond_holds = !c || z;
            COND_GE: cond_holds = (n == v);
            COND_LT: cond_holds = (n != v);
            COND_GT: cond_holds = !z && (n == v);
            COND_LE: cond_holds = z || (n != v);
            COND_AL: cond_holds = 1'b1;
            default: cond_holds = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if
// Bundles the controller <-> datapath signals.
//   master : controller side (reads instruction/ALU_flags, drives strobes)
//   slave  : datapath side
// Signals:
//   instruction[31:0]    IR contents
//   ALU_flags[3:0]       {N,Z,C,V} from the ALU this cycle
//   pc_write, address_source, memory_write, instruction_register_write,
//   register_write, link_write, register_source[1:0], immediate_source[1:0],
//   ALU_source_a, ALU_source_b[1:0], ALU_control[1:0], result_source[1:0]

interface multicycle_controller_if;
    logic [31:0] instruction;
    logic [3:0]  ALU_flags;
    logic        pc_write;
    logic        address_source;
    logic        memory_write;
    logic        instruction_register_write;
    logic        register_write;
    logic        link_write;
    logic [1:0]  register_source;
    logic [1:0]  immediate_source;
    logic        ALU_source_a;
    logic [1:0]  ALU_source_b;
    logic [1:0]  ALU_control;
    logic [1:0]  result_source;

    modport master (
        input  instruction, ALU_flags,
        output pc_write, address_source, memory_write,
               instruction_register_write, register_write, link_write,
               register_source, immediate_source, ALU_source_a,
               ALU_source_b, ALU_control, result_source
    );

    modport slave (
        output instruction, ALU_flags,
        input  pc_write, address_source, memory_write,
               instruction_register_write, register_write, link_write,
               register_source, immediate_source, ALU_source_a,
               ALU_source_b, ALU_control, result_source
    );
endinterface

// File: rtl/condition_check.sv
// condition_check
// Holds the NZCV flags register and evaluates the instruction condition
// against the stored flags.
// Ports:
//   clock, reset       rising-edge clock, async active-high reset
//   cond_i[3:0]        instruction condition field
//   alu_flags_i[3:0]   {N,Z,C,V} from the ALU this cycle
//   nz_write_i         request to update N and Z at this edge
//   cv_write_i         request to update C and V at this edge
//   condition_o        condition passes on the stored flags

module condition_check
    import arm_control_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] cond_i,
    input  logic [3:0] alu_flags_i,
    input  logic       nz_write_i,
    input  logic       cv_write_i,
    output logic       condition_o
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;

    assign condition_o = cond_holds(cond_i, flags_q);

    // A flag-setting instruction whose own condition fails leaves flags alone.
    always_comb begin
        flags_d = flags_q;
        if (nz_write_i && condition_o) begin
            flags_d[3:2] = alu_flags_i[3:2];
        end
        if (cv_write_i && condition_o) begin
            flags_d[1:0] = alu_flags_i[1:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller
// Sequencing FSM for the multicycle Armv4 core: walks each instruction
// through fetch/decode/execute states and issues the per-state datapath
// strobes, gating architectural writes with the condition check.
// Optional feature macro: BRANCH_LINK_EN (adds the LINK state for BL).
// Ports:
//   clock   rising-edge clock
//   reset   asynchronous active-high reset
//   bus     multicycle_controller_if.master (instruction, ALU_flags in;
//           all control strobes/selects out)
// Outputs are Moore: derived from state, instruction and stored flags only.

module multicycle_controller
    import arm_control_pkg::*;
(
    input  logic                           clock,
    input  logic                           reset,
    multicycle_controller_if.master        bus
);

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       unused_fields;

    assign cond          = bus.instruction[31:28];
    assign op            = bus.instruction[27:26];
    assign funct         = bus.instruction[25:20];
    assign rd            = bus.instruction[15:12];
    assign unused_fields = ^{bus.instruction[19:16], bus.instruction[11:0]};

    control_state_t state_q;
    control_state_t state_d;

    // Data-processing decode. Unsupported opcodes run as ADD but never
    // write back and never touch the flags.
    logic [1:0] dp_alu;
    logic       dp_wb;
    logic       dp_cmp;
    logic       dp_supported;
    logic       dp_cv;

    always_comb begin
        dp_alu       = ALU_ADD;
        dp_wb        = 1'b0;
        dp_cmp       = 1'b0;
        dp_supported = 1'b1;
        dp_cv        = 1'b1;
        case (funct[4:1])
            DP_ADD: dp_wb = 1'b1;
            DP_SUB: begin
                dp_alu = ALU_SUB;
                dp_wb  = 1'b1;
            end
            DP_AND: begin
                dp_alu = ALU_AND;
                dp_wb  = 1'b1;
                dp_cv  = 1'b0;
            end
            DP_ORR: begin
                dp_alu = ALU_ORR;
                dp_wb  = 1'b1;
                dp_cv  = 1'b0;
            end
            DP_CMP: begin
                dp_alu = ALU_SUB;
                dp_cmp = 1'b1;
            end
            default: begin
                dp_supported = 1'b0;
                dp_cv        = 1'b0;
            end
        endcase
    end

    logic in_execute;
    logic nz_write;
    logic cv_write;
    logic condition;

    assign in_execute = (state_q == S_EXECUTER) || (state_q == S_EXECUTEI);
    assign nz_write   = in_execute && dp_supported && (funct[0] || dp_cmp);
    assign cv_write   = nz_write && dp_cv;

    condition_check u_condition_check (
        .clock       (clock),
        .reset       (reset),
        .cond_i      (cond),
        .alu_flags_i (bus.ALU_flags),
        .nz_write_i  (nz_write),
        .cv_write_i  (cv_write),
        .condition_o (condition)
    );

    // Next-state logic
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_MEM:    state_d = S_MEMADR;
                    OP_DP:     state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
`ifdef BRANCH_LINK_EN
                    OP_BRANCH: state_d = funct[4] ? S_LINK : S_BRANCH;
`else
                    OP_BRANCH: state_d = S_BRANCH;
`endif
                    default:   state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
`ifdef BRANCH_LINK_EN
            S_LINK:     state_d = S_BRANCH;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Output decode
    logic       pcw;
    logic       asrc;
    logic       mw;
    logic       irw;
    logic       rw;
    logic       lw;
    logic [1:0] rsrc;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] aluc;
    logic [1:0] res;

    always_comb begin
        pcw  = 1'b0;
        asrc = 1'b0;
        mw   = 1'b0;
        irw  = 1'b0;
        rw   = 1'b0;
        lw   = 1'b0;
        rsrc = 2'b00;
        srca = 1'b0;
        srcb = SRCB_REG;
        aluc = ALU_ADD;
        res  = RES_ALUOUT;
        case (state_q)
            S_FETCH: begin
                irw  = 1'b1;
                srca = 1'b1;
                srcb = SRCB_FOUR;
                res  = RES_ALU;
                pcw  = 1'b1;
            end
            S_DECODE: begin
                srca = 1'b1;
                srcb = SRCB_FOUR;
                res  = RES_ALU;
            end
            S_MEMADR: begin
                srcb    = SRCB_IMM;
                rsrc[1] = 1'b1;
            end
            S_MEMREAD: asrc = 1'b1;
            S_MEMWRITE: begin
                asrc    = 1'b1;
                mw      = condition;
                rsrc[1] = 1'b1;
            end
            S_MEMWB: begin
                res = RES_DATA;
                rw  = condition;
                pcw = condition && (rd == REG_PC);
            end
            S_EXECUTER: begin
                srcb = SRCB_REG;
                aluc = dp_alu;
            end
            S_EXECUTEI: begin
                srcb = SRCB_IMM;
                aluc = dp_alu;
            end
            S_ALUWB: begin
                res = RES_ALUOUT;
                rw  = condition && dp_wb;
                pcw = condition && dp_wb && (rd == REG_PC);
            end
            S_BRANCH: begin
                rsrc[0] = 1'b1;
                srcb    = SRCB_IMM;
                res     = RES_ALU;
                pcw     = condition;
            end
`ifdef BRANCH_LINK_EN
            // Writes PC+4 of the branch (current PC register) into R14.
            S_LINK: begin
                srca = 1'b1;
                srcb = SRCB_ZERO;
                res  = RES_ALU;
                lw   = 1'b1;
                rw   = condition;
            end
`endif
            default: ;
        endcase

        // State is already FETCH under async reset; only the strobes need
        // suppressing so nothing architectural moves while reset is held.
        if (reset) begin
            pcw = 1'b0;
            mw  = 1'b0;
            irw = 1'b0;
            rw  = 1'b0;
            lw  = 1'b0;
        end
    end

    assign bus.pc_write                   = pcw;
    assign bus.address_source             = asrc;
    assign bus.memory_write               = mw;
    assign bus.instruction_register_write = irw;
    assign bus.register_write             = rw;
    assign bus.link_write                 = lw;
    assign bus.register_source            = rsrc;
    assign bus.immediate_source           = op;
    assign bus.ALU_source_a               = srca;
    assign bus.ALU_source_b               = srcb;
    assign bus.ALU_control                = aluc;
    assign bus.result_source              = res;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic       pcw;
        logic       asrc;
        logic       mw;
        logic       irw;
        logic       rw;
        logic       lw;
        logic [1:0] rsrc;
        logic [1:0] imm;
        logic       sa;
        logic [1:0] sb;
        logic [1:0] ac;
        logic [1:0] res;
    } ov_t;

    typedef struct packed {
        logic [1:0] alu;
        logic       wb;
        logic       cmp;
        logic       sup;
        logic       cv;
    } dp_t;

    // Cycle roles of an instruction, in order, from FETCH onward.
    typedef enum int {PF, PD, PA, PR, PW, PS, PE, PX, PB, PL} ph_t;

    ov_t act;
    assign act = {bus.pc_write, bus.address_source, bus.memory_write,
                  bus.instruction_register_write, bus.register_write,
                  bus.link_write, bus.register_source, bus.immediate_source,
                  bus.ALU_source_a, bus.ALU_source_b, bus.ALU_control,
                  bus.result_source};

    int   vectors     = 0;
    int   miscompares = 0;
    ov_t  exp_v;
    bit   exp_valid   = 1'b0;
    logic [3:0] mflags = 4'b0000;
    ov_t  cap [0:7];
    int   last_len;

    // Armv4 condition: pick the predicate by cond[3:1], invert with cond[0].
    function automatic logic holds(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        if (cond == 4'hF) return 1'b0;
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return base ^ cond[0];
    endfunction

    function automatic dp_t dp_model(input logic [3:0] code);
        dp_t d;
        case (code)
            4'b0100: d = '{alu: 2'b00, wb: 1'b1, cmp: 1'b0, sup: 1'b1, cv: 1'b1};
            4'b0010: d = '{alu: 2'b01, wb: 1'b1, cmp: 1'b0, sup: 1'b1, cv: 1'b1};
            4'b0000: d = '{alu: 2'b10, wb: 1'b1, cmp: 1'b0, sup: 1'b1, cv: 1'b0};
            4'b1100: d = '{alu: 2'b11, wb: 1'b1, cmp: 1'b0, sup: 1'b1, cv: 1'b0};
            4'b1010: d = '{alu: 2'b01, wb: 1'b0, cmp: 1'b1, sup: 1'b1, cv: 1'b1};
            default: d = '{alu: 2'b00, wb: 1'b0, cmp: 1'b0, sup: 1'b0, cv: 1'b0};
        endcase
        return d;
    endfunction

    function automatic ov_t exp_out(input ph_t ph, input logic [31:0] ins,
                                    input logic [3:0] f);
        ov_t o;
        logic c, rd15;
        dp_t d;
        o     = '0;
        o.imm = ins[27:26];
        c     = holds(ins[31:28], f);
        rd15  = (ins[15:12] == 4'd15);
        d     = dp_model(ins[24:21]);
        case (ph)
            PF: begin o.pcw = 1; o.irw = 1; o.sa = 1; o.sb = 2'b10; o.res = 2'b10; end
            PD: begin o.sa = 1; o.sb = 2'b10; o.res = 2'b10; end
            PA: begin o.sb = 2'b01; o.rsrc = 2'b10; end
            PR: o.asrc = 1;
            PS: begin o.asrc = 1; o.mw = c; o.rsrc = 2'b10; end
            PW: begin o.res = 2'b01; o.rw = c; o.pcw = c & rd15; end
            PE: begin o.sb = ins[25] ? 2'b01 : 2'b00; o.ac = d.alu; end
            PX: begin o.rw = c & d.wb; o.pcw = c & d.wb & rd15; end
            PB: begin o.rsrc = 2'b01; o.sb = 2'b01; o.res = 2'b10; o.pcw = c; end
            PL: begin o.sa = 1; o.sb = 2'b11; o.res = 2'b10; o.lw = 1; o.rw = c; end
            default: ;
        endcase
        return o;
    endfunction

    function automatic ov_t reset_vec(input logic [31:0] ins);
        ov_t o;
        o = exp_out(PF, ins, 4'b0000);
        o.pcw = 0;
        o.irw = 0;
        return o;
    endfunction

    // Single compare process: DUT outputs against the model every cycle.
    always @(negedge clock) begin
        if (exp_valid) begin
            vectors++;
            if (act !== exp_v) begin
                miscompares++;
                $display("FAIL outputs @%0t: got %b want %b", $time, act, exp_v);
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] a, input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    // Runs one instruction from its FETCH cycle. abort_k >= 0 asserts reset
    // in that cycle and stops; the next call releases reset.
    task automatic run_instr(input logic [31:0] ins, input logic [3:0] fl_ex,
                             input bit use_fl, input int abort_k);
        ph_t sch[$];
        dp_t d;
        bit  c;
        sch = {PF, PD};
        case (ins[27:26])
            2'b01: begin
                sch.push_back(PA);
                if (ins[20]) begin sch.push_back(PR); sch.push_back(PW); end
                else sch.push_back(PS);
            end
            2'b00: begin sch.push_back(PE); sch.push_back(PX); end
            2'b10: begin
`ifdef BRANCH_LINK_EN
                if (ins[24]) sch.push_back(PL);
`endif
                sch.push_back(PB);
            end
            default: ;
        endcase
        last_len = sch.size();
        for (int k = 0; k < sch.size(); k++) begin
            @(posedge clock);
            #1;
            if (k == 0) reset = 1'b0;
            if (k == 1) bus.instruction = ins;
            bus.ALU_flags = (use_fl && sch[k] == PE) ? fl_ex : 4'($urandom);
            if (k == abort_k) begin
                reset = 1'b1;
                exp_v = reset_vec(bus.instruction);
            end else begin
                exp_v = exp_out(sch[k], bus.instruction, mflags);
            end
            exp_valid = 1'b1;
            @(negedge clock);
            #1;
            cap[k] = act;
            if (k == abort_k) begin
                mflags   = 4'b0000;
                last_len = k + 1;
                break;
            end
            if (sch[k] == PE) begin
                d = dp_model(ins[24:21]);
                c = holds(ins[31:28], mflags);
                if (d.sup && (ins[20] || d.cmp) && c) begin
                    mflags[3:2] = bus.ALU_flags[3:2];
                    if (d.cv) mflags[1:0] = bus.ALU_flags[1:0];
                end
            end
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [3:0]  codes [0:7];
        int          cls, idx;
        logic [5:0]  funct;
        logic [3:0]  cond;
        codes = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010,
                  4'b0001, 4'b0101, 4'b1101};
        ins   = $urandom;
        cond  = 4'($urandom_range(0, 15));
        cls   = $urandom_range(0, 5);
        funct = 6'($urandom);
        case (cls)
            0, 1: begin
                idx = $urandom_range(0, 7);
                funct[4:1] = codes[idx];
                if (idx == 4) funct[0] = 1'b1;
                else if (idx > 4) funct[0] = 1'b0;
                if (funct[0]) cond = 4'b1110;
                ins[27:26] = 2'b00;
            end
            2: ins[27:26] = 2'b01;
            3: ins[27:26] = 2'b10;
            4: ins[27:26] = 2'b11;
            default: begin ins[27:26] = 2'b01; funct[0] = 1'b1; end
        endcase
        ins[31:28] = cond;
        ins[25:20] = funct;
        return ins;
    endfunction

    initial begin
        bus.instruction = 32'h0;
        bus.ALU_flags   = 4'h0;
        exp_v           = reset_vec(32'h0);
        exp_valid       = 1'b1;
        @(negedge clock);
        #1;
        lit("reset_outputs", {15'b0, act}, {15'b0, 17'b00000000001100010});

        // ADDS R1,R2,R3 with Z from the ALU, then EQ / NE variants
        run_instr(32'hE0921003, 4'b0100, 1, -1);
        lit("adds_z_latched", {31'b0, mflags[2]}, 1);
        run_instr(32'h00821003, 4'b0000, 0, -1);
        lit("addeq_rw", {31'b0, cap[3].rw}, 1);
        lit("addeq_len", last_len, 4);
        run_instr(32'h10821003, 4'b0000, 0, -1);
        lit("addne_rw", {31'b0, cap[3].rw}, 0);
        lit("addne_len", last_len, 4);

        // LDR R15,[R1]
        run_instr(32'hE591F000, 4'b0000, 0, -1);
        lit("ldr15_rw", {31'b0, cap[4].rw}, 1);
        lit("ldr15_pcw", {31'b0, cap[4].pcw}, 1);
        lit("ldr15_res", {30'b0, cap[4].res}, 1);
        lit("ldr_len", last_len, 5);

        // STR R2,[R1,#4]
        run_instr(32'hE5812004, 4'b0000, 0, -1);
        lit("str_mw", {31'b0, cap[3].mw}, 1);
        lit("str_asrc", {31'b0, cap[3].asrc}, 1);
        lit("str_rsrc1", {31'b0, cap[3].rsrc[1]}, 1);
        lit("str_len", last_len, 4);

        // CMP sets N, then BLT taken, BGE not
        run_instr(32'hE1510002, 4'b1000, 1, -1);
        run_instr(32'hBA000000, 4'b0000, 0, -1);
        lit("blt_pcw", {31'b0, cap[2].pcw}, 1);
        lit("b_len", last_len, 3);
        run_instr(32'hAA000000, 4'b0000, 0, -1);
        lit("bge_pcw", {31'b0, cap[2].pcw}, 0);

        // BL
        run_instr(32'hEB000000, 4'b0000, 0, -1);
`ifdef BRANCH_LINK_EN
        lit("bl_lw", {31'b0, cap[2].lw}, 1);
        lit("bl_sb", {30'b0, cap[2].sb}, 3);
        lit("bl_len", last_len, 4);
`else
        lit("bl_lw", {31'b0, cap[2].lw}, 0);
        lit("bl_len", last_len, 3);
`endif

        // Reset in MEMREAD of an LDR, then a full LDR after release
        run_instr(32'hE5912000, 4'b0000, 0, 3);
        lit("abort_rw", {31'b0, cap[3].rw}, 0);
        lit("abort_irw", {31'b0, cap[3].irw}, 0);
        run_instr(32'hE5912000, 4'b0000, 0, -1);
        lit("post_reset_irw", {31'b0, cap[0].irw}, 1);
        lit("post_reset_len", last_len, 5);

        // Randomized instruction stream
        for (int i = 0; i < 300; i++) begin
            run_instr(rand_instr(), 4'b0000, 0, -1);
        end

        @(posedge clock);
        #1;
        exp_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
